// File: rtl/asc2dec_parser_if.sv
// Byte-stream input and parsed-operand output bundle for asc2dec_parser.
// The slave modport faces the parser; the master modport faces the UART/sequencer side.
interface asc2dec_parser_if #(
    parameter int DATA_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [DATA_W-1:0] num_o;
    logic [7:0]        term_o;
    logic              num_valid;
    logic              ovf_o;
    logic              err_o;
    logic              busy;

    modport slave (
        input  rx_valid, rx_data,
        output num_o, term_o, num_valid, ovf_o, err_o, busy
    );

    modport master (
        output rx_valid, rx_data,
        input  num_o, term_o, num_valid, ovf_o, err_o, busy
    );
endinterface

// File: rtl/asc2dec_parser.sv
// ASCII decimal operand parser: accumulates digits into an unsigned value and
// emits it with its terminator byte; malformed input produces an error pulse.
module asc2dec_parser #(
    parameter int DATA_W     = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    asc2dec_parser_if.slave   bus
);
    localparam int CW  = $clog2(MAX_DIGITS + 2);
    localparam int T_W = DATA_W + 4;

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovfs_q, ovfs_d;
    logic [DATA_W-1:0] num_q, num_d;
    logic [7:0]        term_q, term_d;
    logic              ovf_q, ovf_d;
    logic              nv_q, nv_d;
    logic              err_q, err_d;

    logic              is_digit, is_term, is_space;
    logic [3:0]        dig;
    logic [T_W-1:0]    t;

    assign dig      = bus.rx_data[3:0];
    assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_space = (bus.rx_data == 8'h20);
    assign is_term  = (bus.rx_data == 8'h2B) || (bus.rx_data == 8'h2D) ||
                      (bus.rx_data == 8'h2A) || (bus.rx_data == 8'h2F) ||
                      (bus.rx_data == 8'h3D) || (bus.rx_data == 8'h0D);
    // Four spare bits hold acc*10+9 without wrap for any DATA_W.
    assign t = {4'b0, acc_q} * T_W'(10) + {{DATA_W{1'b0}}, dig};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovfs_d  = ovfs_q;
        num_d   = num_q;
        term_d  = term_q;
        ovf_d   = ovf_q;
        nv_d    = 1'b0;
        err_d   = 1'b0;
        if (bus.rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_digit) begin
                        acc_d   = {{(DATA_W-4){1'b0}}, dig};
                        cnt_d   = CW'(1);
                        ovfs_d  = 1'b0;
                        state_d = ACCUM;
                    end else if (!is_space) begin
                        err_d = 1'b1;
                    end
                end
                ACCUM: begin
                    if (is_digit) begin
                        if (cnt_q != CW'(MAX_DIGITS + 1))
                            cnt_d = cnt_q + 1'b1;
                        // Too many digits, or already saturated: value is frozen.
                        if (cnt_q >= CW'(MAX_DIGITS) || ovfs_q) begin
                            ovfs_d = 1'b1;
                        end else if (t[T_W-1:DATA_W] != 4'b0) begin
                            acc_d  = {DATA_W{1'b1}};
                            ovfs_d = 1'b1;
                        end else begin
                            acc_d = t[DATA_W-1:0];
                        end
                    end else if (is_term) begin
                        num_d   = acc_q;
                        term_d  = bus.rx_data;
                        ovf_d   = ovfs_q;
                        nv_d    = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovfs_q  <= 1'b0;
            num_q   <= '0;
            term_q  <= '0;
            ovf_q   <= 1'b0;
            nv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovfs_q  <= ovfs_d;
            num_q   <= num_d;
            term_q  <= term_d;
            ovf_q   <= ovf_d;
            nv_q    <= nv_d;
            err_q   <= err_d;
        end
    end

    assign bus.num_o     = num_q;
    assign bus.term_o    = term_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.num_valid = nv_q;
    assign bus.err_o     = err_q;
    assign bus.busy      = (state_q == ACCUM);
endmodule

// File: tb/tb_asc2dec_parser.sv
// Directed bench for asc2dec_parser; expected pulses are queued at drive time
// and matched (content and cycle) by a monitor sampling on the falling edge.
module tb_asc2dec_parser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    typedef struct {
        bit          err;
        logic [15:0] num;
        logic [7:0]  term;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] h_num  = '0;
    logic [7:0]  h_term = '0;
    logic        h_ovf  = 1'b0;

    asc2dec_parser_if #(.DATA_W(16)) bus ();

    asc2dec_parser #(.DATA_W(16), .MAX_DIGITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one byte for one cycle, then 'gap' idle cycles.
    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Call right before sending the byte that should trigger the pulse.
    task automatic exp_num(input logic [15:0] n, input logic [7:0] t, input logic o);
        exp_t e;
        e.err = 1'b0; e.num = n; e.term = t; e.ovf = o; e.cyc = cyc + 1;
        sb.push_back(e);
        h_num = n; h_term = t; h_ovf = o;
    endtask

    task automatic exp_err();
        exp_t e;
        e.err = 1'b1; e.num = h_num; e.term = h_term; e.ovf = h_ovf; e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, sb.size(), 0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (bus.num_valid || bus.err_o) begin
                    chk("pulse_excl", {bus.num_valid, bus.err_o}, {1'b0, bus.err_o} | {bus.num_valid, 1'b0} & 2'b10 | (bus.num_valid ? 2'b10 : 2'b01));
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", {bus.num_valid, bus.err_o}, 2'b00);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("kind",  {bus.num_valid, bus.err_o}, e.err ? 2'b01 : 2'b10);
                        chk("num",   bus.num_o,  e.num);
                        chk("term",  bus.term_o, e.term);
                        chk("ovf",   bus.ovf_o,  e.ovf);
                        chk("cycle", cyc,        e.cyc);
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: observed timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_num",  bus.num_o, 0);
        chk("rst_flags", {bus.term_o, bus.num_valid, bus.ovf_o, bus.err_o, bus.busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: "123=" with gaps
        send("1", 1);
        chk("busy_accum", bus.busy, 1'b1);
        send("2", 1);
        send("3", 1);
        exp_num(16'd123, 8'h3D, 1'b0);
        send("=", 1);
        drain("t1");
        chk("busy_idle", bus.busy, 1'b0);

        // 2: exact max then one past max
        send("6", 0); send("5", 0); send("5", 0); send("3", 0); send("5", 0);
        exp_num(16'd65535, 8'h2B, 1'b0);
        send("+", 0);
        send("6", 0); send("5", 0); send("5", 0); send("3", 0); send("6", 0);
        exp_num(16'hFFFF, 8'h2D, 1'b1);
        send("-", 1);
        drain("t2");

        // 3: six digits
        send("1", 0); send("2", 0); send("3", 0); send("4", 0); send("5", 0); send("6", 0);
        exp_num(16'd12345, 8'h2A, 1'b1);
        send("*", 1);
        drain("t3");

        // 4: OTHER mid-number, then recovery
        send("1", 0); send("2", 0);
        exp_err();
        send("a", 0);
        chk("busy_after_err", bus.busy, 1'b0);
        send("7", 0);
        exp_num(16'd7, 8'h0D, 1'b0);
        send(8'h0D, 1);
        drain("t4");

        // 5: terminator in IDLE, spaces ignored, then "9/"
        exp_err();
        send("=", 1);
        send(" ", 0); send(" ", 2);
        send("9", 0);
        exp_num(16'd9, 8'h2F, 1'b0);
        send("/", 1);
        // space inside a number is malformed
        send("5", 0);
        exp_err();
        send(" ", 1);
        drain("t5");

        // 6: reset mid-number, then back-to-back numbers
        send("4", 0); send("5", 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_num", bus.num_o, 0);
        chk("rst2_flags", {bus.term_o, bus.num_valid, bus.ovf_o, bus.err_o, bus.busy}, 0);
        h_num = '0; h_term = '0; h_ovf = 1'b0;
        send("9", 0);
        exp_num(16'd9, 8'h3D, 1'b0);
        send("=", 0);
        send("1", 0);
        exp_num(16'd1, 8'h2B, 1'b0);
        send("+", 0);
        send("2", 0);
        exp_num(16'd2, 8'h2D, 1'b0);
        send("-", 2);
        drain("t6");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
